sync_fifo_ext: RTL and testbench

Parametrised synchronous FIFO built on an internal registered-read memory array.
- Supports full and empty detection, an occupancy count and programmable almost-full/almost-empty thresholds.
- Read data is registered and qualified by a valid strobe.
- Optional sticky overflow/underflow error flags.
- Sits between a producer and a consumer in the same clock domain, e.g. UART RX/TX buffering.

---
 rtl/sync_fifo_ext.sv | 128 ++++++++++++
 tb/tb_sync_fifo_ext.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_ext.sv
// Synchronous FIFO with a registered read port, occupancy count and almost-full/empty thresholds.
// Optional sticky overflow/underflow flags are built when SYNC_FIFO_EXT_ERR_FLAGS_EN is defined.
module sync_fifo_ext #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_THRESH  = 2**ADDR_WIDTH - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  r_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  input  logic                  err_clr,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   AF_C    = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0]   AE_C    = (ADDR_WIDTH+1)'(AE_THRESH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] w_ptr_q, w_ptr_d;
  logic [ADDR_WIDTH-1:0] r_ptr_q, r_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
  logic                  r_valid_q, r_valid_d;
  logic                  rd_acc, wr_acc;

  // Handshake: a write is taken when wr_en is high and the FIFO is not full
  // (or a read frees a slot in the same cycle); a read is taken when rd_en is
  // high and the FIFO is not empty, with r_valid marking the data one cycle later.
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);

  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_acc);

  always_comb begin
    w_ptr_d   = w_ptr_q;
    r_ptr_d   = r_ptr_q;
    count_d   = count_q;
    r_data_d  = r_data_q;
    r_valid_d = 1'b0;
    if (wr_acc) w_ptr_d = w_ptr_q + PTR_ONE;
    if (rd_acc) begin
      r_ptr_d   = r_ptr_q + PTR_ONE;
      r_data_d  = mem_q[r_ptr_q];
      r_valid_d = 1'b1;
    end
    if (wr_acc && !rd_acc) count_d = count_q + CNT_ONE;
    else if (rd_acc && !wr_acc) count_d = count_q - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_ptr_q   <= '0;
      r_ptr_q   <= '0;
      count_q   <= '0;
      r_data_q  <= '0;
      r_valid_q <= 1'b0;
    end else begin
      w_ptr_q   <= w_ptr_d;
      r_ptr_q   <= r_ptr_d;
      count_q   <= count_d;
      r_data_q  <= r_data_d;
      r_valid_q <= r_valid_d;
    end
  end

  // Storage is deliberately left unreset; stale words are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (wr_acc && !reset) mem_q[w_ptr_q] <= w_data;
  end

  assign r_data  = r_data_q;
  assign r_valid = r_valid_q;
  assign count   = count_q;

`ifdef SYNC_FIFO_EXT_ERR_FLAGS_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  // A set condition coinciding with err_clr keeps the flag high.
  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (err_clr) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (wr_en & full & ~rd_acc) ovf_d = 1'b1;
    if (rd_en & empty)          udf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = udf_q;
`else
  logic err_clr_unused;
  assign err_clr_unused = err_clr;
  assign overflow       = 1'b0;
  assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_ext.sv
// Self-checking bench for sync_fifo_ext: directed scenarios plus random traffic,
// all checked against a queue-based reference of the FIFO contents and flags.
module tb_sync_fifo_ext;

  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] w_data = '0;
  logic       rd_en = 1'b0;
  logic [7:0] r_data;
  logic       r_valid;
  logic       full, empty, almost_full, almost_empty;
  logic [4:0] count;
  logic       err_clr = 1'b0;
  logic       overflow, underflow;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [7:0] exp_q[$];
  logic [7:0] exp_rdata  = '0;
  logic       exp_rvalid = 1'b0;
  logic       exp_ovf    = 1'b0;
  logic       exp_udf    = 1'b0;

  sync_fifo_ext #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .AF_THRESH(AF), .AE_THRESH(AE)
  ) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .w_data(w_data), .rd_en(rd_en),
    .r_data(r_data), .r_valid(r_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .err_clr(err_clr), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic model_step(input logic rst, input logic wr, input logic [7:0] wd,
                            input logic rd, input logic clr);
    int  n;
    bit  rd_ok, wr_ok;
    n = exp_q.size();
    if (rst) begin
      exp_q.delete();
      exp_rdata  = '0;
      exp_rvalid = 1'b0;
      exp_ovf    = 1'b0;
      exp_udf    = 1'b0;
    end else begin
      rd_ok = rd && (n > 0);
      wr_ok = wr && ((n < DEPTH) || rd_ok);
`ifdef SYNC_FIFO_EXT_ERR_FLAGS_EN
      if (wr && n == DEPTH && !rd_ok) exp_ovf = 1'b1;
      else if (clr)                   exp_ovf = 1'b0;
      if (rd && n == 0)               exp_udf = 1'b1;
      else if (clr)                   exp_udf = 1'b0;
`endif
      if (rd_ok) begin
        exp_rdata  = exp_q.pop_front();
        exp_rvalid = 1'b1;
      end else begin
        exp_rvalid = 1'b0;
      end
      if (wr_ok) exp_q.push_back(wd);
    end
  endtask

  // driver: one clock with the given inputs, model advanced at the edge
  task automatic do_cycle(input logic rst, input logic wr, input logic [7:0] wd,
                          input logic rd, input logic clr);
    reset = rst; wr_en = wr; w_data = wd; rd_en = rd; err_clr = clr;
    @(posedge clk);
    model_step(rst, wr, wd, rd, clr);
    #1;
    reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
  endtask

  task automatic test_reset;
    do_cycle(1, 0, 8'h00, 0, 0);
    do_cycle(1, 0, 8'h00, 0, 0);
    total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count: got %0d exp 0", count); end
    total++; if ({full, empty, almost_full, almost_empty} !== 4'b0101) begin
      bad++; $display("FAIL reset_flags: got f=%b e=%b af=%b ae=%b exp 0 1 0 1", full, empty, almost_full, almost_empty);
    end
    total++; if (r_data !== 8'h00 || r_valid !== 1'b0) begin
      bad++; $display("FAIL reset_rd: got r_data=%0h r_valid=%b exp 0 0", r_data, r_valid);
    end
    total++; if (overflow !== 1'b0 || underflow !== 1'b0) begin
      bad++; $display("FAIL reset_err: got ovf=%b udf=%b exp 0 0", overflow, underflow);
    end
  endtask

  task automatic test_fill;
    for (int i = 1; i <= DEPTH; i++) begin
      do_cycle(0, 1, 8'(i), 0, 0);
      total++; if (count !== 5'(i)) begin bad++; $display("FAIL fill_count: got %0d exp %0d", count, i); end
      total++; if (almost_full !== (i >= AF) || full !== (i == DEPTH)) begin
        bad++; $display("FAIL fill_flags at %0d: got af=%b f=%b", i, almost_full, full);
      end
    end
    do_cycle(0, 1, 8'hAA, 0, 0);
    total++; if (count !== 5'd16) begin bad++; $display("FAIL overfill_count: got %0d exp 16", count); end
    total++; if (overflow !== exp_ovf) begin bad++; $display("FAIL overflow_set: got %b exp %b", overflow, exp_ovf); end
  endtask

  task automatic test_drain;
    for (int i = 1; i <= DEPTH; i++) begin
      do_cycle(0, 0, 8'h00, 1, 0);
      total++; if (r_valid !== 1'b1 || r_data !== 8'(i)) begin
        bad++; $display("FAIL drain_data %0d: got v=%b d=%0h exp 1 %0h", i, r_valid, r_data, i);
      end
      total++; if (count !== 5'(DEPTH - i) || almost_empty !== ((DEPTH - i) <= AE) || empty !== (i == DEPTH)) begin
        bad++; $display("FAIL drain_flags %0d: got cnt=%0d ae=%b e=%b", i, count, almost_empty, empty);
      end
    end
    do_cycle(0, 0, 8'h00, 1, 0);
    total++; if (r_valid !== 1'b0 || r_data !== 8'h10) begin
      bad++; $display("FAIL underread: got v=%b d=%0h exp 0 10", r_valid, r_data);
    end
    total++; if (underflow !== exp_udf) begin bad++; $display("FAIL underflow_set: got %b exp %b", underflow, exp_udf); end
  endtask

  task automatic test_err_clr;
    total++; if (overflow !== exp_ovf) begin bad++; $display("FAIL ovf_sticky: got %b exp %b", overflow, exp_ovf); end
    do_cycle(0, 0, 8'h00, 0, 1);
    total++; if (overflow !== 1'b0 || underflow !== 1'b0) begin
      bad++; $display("FAIL err_clr: got ovf=%b udf=%b exp 0 0", overflow, underflow);
    end
  endtask

  task automatic test_full_simul;
    logic [7:0] words[DEPTH+1];
    for (int i = 0; i < DEPTH; i++) begin
      words[i] = 8'($urandom_range(0, 255));
      do_cycle(0, 1, words[i], 0, 0);
    end
    words[DEPTH] = 8'h5C;
    do_cycle(0, 1, 8'h5C, 1, 0);
    total++; if (count !== 5'd16 || full !== 1'b1) begin bad++; $display("FAIL fullrw_count: got %0d f=%b exp 16 1", count, full); end
    total++; if (r_valid !== 1'b1 || r_data !== words[0]) begin
      bad++; $display("FAIL fullrw_data: got v=%b d=%0h exp 1 %0h", r_valid, r_data, words[0]);
    end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fullrw_ovf: got %b exp 0", overflow); end
    for (int i = 1; i <= DEPTH; i++) begin
      do_cycle(0, 0, 8'h00, 1, 0);
      total++; if (r_data !== words[i]) begin bad++; $display("FAIL fullrw_order %0d: got %0h exp %0h", i, r_data, words[i]); end
    end
  endtask

  task automatic test_empty_simul;
    logic [7:0] held;
    held = exp_rdata;
    do_cycle(0, 1, 8'h3C, 1, 0);
    total++; if (r_valid !== 1'b0 || r_data !== held || count !== 5'd1) begin
      bad++; $display("FAIL emptyrw: got v=%b d=%0h cnt=%0d exp 0 %0h 1", r_valid, r_data, count, held);
    end
    total++; if (underflow !== exp_udf) begin bad++; $display("FAIL emptyrw_udf: got %b exp %b", underflow, exp_udf); end
    do_cycle(0, 0, 8'h00, 1, 0);
    total++; if (r_valid !== 1'b1 || r_data !== 8'h3C) begin
      bad++; $display("FAIL emptyrw_read: got v=%b d=%0h exp 1 3c", r_valid, r_data);
    end
    do_cycle(0, 0, 8'h00, 0, 1);
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 40; i++) begin
      do_cycle(0, 1, 8'(8'h40 + i), 0, 0);
      do_cycle(0, 0, 8'h00, 1, 0);
      total++; if (r_valid !== 1'b1 || r_data !== 8'(8'h40 + i)) begin
        bad++; $display("FAIL wrap %0d: got v=%b d=%0h exp 1 %0h", i, r_valid, r_data, 8'(8'h40 + i));
      end
    end
  endtask

  task automatic test_random;
    int n;
    for (int c = 0; c < 400; c++) begin
      do_cycle(0, 1'($urandom_range(0, 99) < 55), 8'($urandom), 1'($urandom_range(0, 99) < 45),
               1'($urandom_range(0, 49) == 0));
      n = exp_q.size();
      total++; if (count !== 5'(n) || r_valid !== exp_rvalid || r_data !== exp_rdata) begin
        bad++; $display("FAIL rand_data c=%0d: got cnt=%0d v=%b d=%0h exp %0d %b %0h", c, count, r_valid, r_data, n, exp_rvalid, exp_rdata);
      end
      total++; if (full !== (n == DEPTH) || empty !== (n == 0) || almost_full !== (n >= AF) || almost_empty !== (n <= AE)) begin
        bad++; $display("FAIL rand_flags c=%0d: got f=%b e=%b af=%b ae=%b n=%0d", c, full, empty, almost_full, almost_empty, n);
      end
      total++; if (overflow !== exp_ovf || underflow !== exp_udf) begin
        bad++; $display("FAIL rand_err c=%0d: got ovf=%b udf=%b exp %b %b", c, overflow, underflow, exp_ovf, exp_udf);
      end
    end
  endtask

  task automatic test_reset_mid;
    do_cycle(1, 0, 8'h00, 0, 0);
    for (int i = 0; i <= DEPTH; i++) do_cycle(0, 1, 8'(8'hA0 + i), 0, 0);
    for (int i = 0; i < 9; i++) do_cycle(0, 0, 8'h00, 1, 0);
    total++; if (count !== 5'd7 || overflow !== exp_ovf) begin
      bad++; $display("FAIL premid: got cnt=%0d ovf=%b exp 7 %b", count, overflow, exp_ovf);
    end
    do_cycle(1, 1, 8'hEE, 1, 0);
    total++; if (count !== 5'd0 || empty !== 1'b1 || almost_empty !== 1'b1 || full !== 1'b0) begin
      bad++; $display("FAIL midreset_state: got cnt=%0d e=%b ae=%b f=%b exp 0 1 1 0", count, empty, almost_empty, full);
    end
    total++; if (r_data !== 8'h00 || r_valid !== 1'b0 || overflow !== 1'b0) begin
      bad++; $display("FAIL midreset_out: got d=%0h v=%b ovf=%b exp 0 0 0", r_data, r_valid, overflow);
    end
    do_cycle(0, 0, 8'h00, 1, 0);
    total++; if (r_valid !== 1'b0 || count !== 5'd0) begin
      bad++; $display("FAIL midreset_discard: got v=%b cnt=%0d exp 0 0", r_valid, count);
    end
  endtask

  initial begin
    test_reset;
    test_fill;
    test_drain;
    test_err_clr;
    test_full_simul;
    test_empty_simul;
    test_wrap;
    test_random;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
